// File: rtl/tnet_pkg.sv
// tnet_pkg: shared types and constants for the timing-network node.
//   TYPE_ARB_ST - TX arbiter FSM states (debug-visible encoding)
//   GRANT_LOC / GRANT_NET - grant encoding used by the arbiters
package tnet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_REL  = 2'd2
    } TYPE_ARB_ST;

    localparam logic GRANT_LOC = 1'b0;
    localparam logic GRANT_NET = 1'b1;

endpackage

// File: rtl/tnet_arb_pick2.sv
// tnet_arb_pick2: two-way round-robin pick, purely combinational.
//   loc_req, net_req - pending requests
//   last_grant       - previous winner (GRANT_LOC / GRANT_NET)
//   valid            - at least one request pending
//   grant            - winner; on a tie the source not granted last time wins
module tnet_arb_pick2
    import tnet_pkg::*;
(
    input  logic loc_req,
    input  logic net_req,
    input  logic last_grant,
    output logic valid,
    output logic grant
);

    always_comb begin
        valid = loc_req | net_req;
        grant = GRANT_LOC;
        if (loc_req && net_req) begin
            grant = ~last_grant;
        end else if (net_req) begin
            grant = GRANT_NET;
        end
    end

endmodule

// File: rtl/tnet_tx_arbiter.sv
// tnet_tx_arbiter: owns the single Aurora TX command slot and shares it
// between local commands and network-forward commands.
//   c_clk_i, c_rst_ni        - core clock, synchronous active-low reset
//   link_ready_i             - Aurora channel up; no grant without it
//   loc_req_i/header/dt      - local source request + word set, loc_ack_o back
//   net_req_i/header/dt      - forward source request + word set, net_ack_o back
//   ack_err_o                - qualifies either ack: 1 = aborted
//   tx_req_o/header/dt       - registered request + word set to the link
//   tx_ack_i                 - link accepted the word set
//   tx_cnt_o, err_cnt_o      - completed (wrapping) / aborted (saturating) counts
//   st_do                    - FSM state for debug
module tnet_tx_arbiter
    import tnet_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic        c_clk_i,
    input  logic        c_rst_ni,
    input  logic        link_ready_i,
    input  logic        loc_req_i,
    input  logic [63:0] loc_header_i,
    input  logic [63:0] loc_dt_i,
    output logic        loc_ack_o,
    input  logic        net_req_i,
    input  logic [63:0] net_header_i,
    input  logic [63:0] net_dt_i,
    output logic        net_ack_o,
    output logic        ack_err_o,
    output logic        tx_req_o,
    output logic [63:0] tx_header_o,
    output logic [63:0] tx_dt_o,
    input  logic        tx_ack_i,
    output logic [15:0] tx_cnt_o,
    output logic [7:0]  err_cnt_o,
    output logic [1:0]  st_do
);

    // Last count value before the abort fires: tx_req_o stays up TIMEOUT cycles.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    TYPE_ARB_ST  state;
    logic        last_grant;
    logic        grant;
    logic [15:0] tmo_cnt;

    logic        pick_valid;
    logic        pick_grant;
    logic        grant_req;

    tnet_arb_pick2 u_pick (
        .loc_req    (loc_req_i),
        .net_req    (net_req_i),
        .last_grant (last_grant),
        .valid      (pick_valid),
        .grant      (pick_grant)
    );

    // Only the granted source can release ST_REL.
    assign grant_req = (grant == GRANT_NET) ? net_req_i : loc_req_i;
    assign st_do     = state;

    always_ff @(posedge c_clk_i) begin
        if (!c_rst_ni) begin
            state       <= ST_IDLE;
            last_grant  <= GRANT_LOC;
            grant       <= GRANT_LOC;
            tmo_cnt     <= '0;
            tx_req_o    <= 1'b0;
            tx_header_o <= '0;
            tx_dt_o     <= '0;
            loc_ack_o   <= 1'b0;
            net_ack_o   <= 1'b0;
            ack_err_o   <= 1'b0;
            tx_cnt_o    <= '0;
            err_cnt_o   <= '0;
        end else begin
            // Acks are single-cycle pulses; only ST_TX re-asserts them.
            loc_ack_o <= 1'b0;
            net_ack_o <= 1'b0;
            ack_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (link_ready_i && pick_valid) begin
                        grant      <= pick_grant;
                        last_grant <= pick_grant;
                        tmo_cnt    <= '0;
                        tx_req_o   <= 1'b1;
                        if (pick_grant == GRANT_NET) begin
                            tx_header_o <= net_header_i;
                            tx_dt_o     <= net_dt_i;
                        end else begin
                            tx_header_o <= loc_header_i;
                            tx_dt_o     <= loc_dt_i;
                        end
                        state <= ST_TX;
                    end
                end
                ST_TX: begin
                    // A same-cycle ack beats both abort causes.
                    if (tx_ack_i) begin
                        tx_req_o  <= 1'b0;
                        loc_ack_o <= (grant == GRANT_LOC);
                        net_ack_o <= (grant == GRANT_NET);
                        tx_cnt_o  <= tx_cnt_o + 16'd1;
                        state     <= ST_REL;
                    end else if (tmo_cnt == TMO_LAST || !link_ready_i) begin
                        tx_req_o  <= 1'b0;
                        loc_ack_o <= (grant == GRANT_LOC);
                        net_ack_o <= (grant == GRANT_NET);
                        ack_err_o <= 1'b1;
                        if (err_cnt_o != 8'hFF) begin
                            err_cnt_o <= err_cnt_o + 8'd1;
                        end
                        state <= ST_REL;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                ST_REL: begin
                    if (!grant_req) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx_req_o <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/tnet_tx_arbiter.md
# tnet_tx_arbiter

Arbitrates the single Aurora TX command slot between the two command sources of the timing-network node: local commands issued by the tProc/AXI command decoder, and network commands that must be forwarded downstream. It latches the winner's header and payload, drives the link's tx_req/tx_ack handshake, and applies an ack timeout. It also aborts on link loss and returns a per-transaction acknowledge with an error flag to the requester. It sits in the c_clk_i domain between the command processor and the Aurora link controller.

## Interface

Parameters:
- TIMEOUT, 1023: c_clk_i cycles to wait for tx_ack_i before aborting; legal range 1..65535.

Ports (one clock; reset is synchronous and active-low):
- c_clk_i  in  1  core clock; all logic on its rising edge
- c_rst_ni  in  1  synchronous active-low reset
- link_ready_i  in  1  Aurora channel up
- loc_req_i  in  1  local request, level
- loc_header_i  in  64  local command header
- loc_dt_i  in  64  local payload {dt1, dt2}
- loc_ack_o  out  1  one-cycle acknowledge to local source
- net_req_i  in  1  network-forward request, level
- net_header_i  in  64  forward header
- net_dt_i  in  64  forward payload {dt1, dt2}
- net_ack_o  out  1  one-cycle acknowledge to network source
- ack_err_o  out  1  valid with either ack; 1 = aborted (timeout or link loss)
- tx_req_o  out  1  request to link, level
- tx_header_o  out  64  registered header
- tx_dt_o  out  64  registered payload
- tx_ack_i  in  1  link accepted the word set
- tx_cnt_o  out  16  completed transfers, wrapping
- err_cnt_o  out  8  aborted transfers, saturating at 255
- st_do  out  2  state, debug

## Operation

- States: ST_IDLE (0), ST_TX (1), ST_REL (2); code 3 is unreachable and recovers to ST_IDLE.
- ST_IDLE:
  - No grant is issued while link_ready_i = 0.
  - Otherwise, if either request is high, select the winner, latch its header and payload into tx_header_o/tx_dt_o, record the grant, set tx_req_o, and go to ST_TX.
- Selection:
  - A single requester always wins.
  - On a tie, use round-robin against the last grant. The last grant resets to loc, so net wins the first tie after reset.
- ST_TX:
  - On tx_ack_i: clear tx_req_o, pulse the granted ack with ack_err_o = 0, increment tx_cnt_o, and go to ST_REL.
  - On timeout or link_ready_i = 0, with no tx_ack_i in the same cycle: clear tx_req_o, pulse the granted ack with ack_err_o = 1, increment err_cnt_o, and go to ST_REL.
  - tx_ack_i has priority over an abort in the same cycle.
- ST_REL: ack and ack_err_o return to 0. Stay until the granted request is low, then go to ST_IDLE. The other requester does not affect ST_REL.
- Timeout counter: 16 bits, cleared on entry to ST_TX, incremented each ST_TX cycle. Timeout fires when the count reaches TIMEOUT - 1 without tx_ack_i, so tx_req_o is high for exactly TIMEOUT cycles.
- tx_ack_i outside ST_TX is ignored.
- tx_header_o/tx_dt_o hold their last value outside ST_TX.

## Timing

- Reset values: every output is 0 and the state is ST_IDLE. A reset in any state abandons the transfer with no ack and no counter change.
- Request high and link ready at edge k: tx_req_o and the latched data are valid after edge k.
- tx_ack_i high at edge m: tx_req_o is low and the ack is high after edge m. The ack is exactly one cycle wide.
- Minimum back-to-back transfer is 4 cycles: IDLE, TX with immediate ack, REL with request dropped, IDLE.
- Requesters must hold their request and data stable until their ack, and drop the request in the cycle after the ack.
- Counters: tx_cnt_o wraps from 0xFFFF to 0x0000. err_cnt_o holds at 0xFF.

## Structure

- Shared package tnet_pkg holds:
  - TYPE_ARB_ST enum: ST_IDLE, ST_TX, ST_REL.
  - localparam GRANT_LOC = 1'b0, GRANT_NET = 1'b1.
- One combinational sub-module, tnet_arb_pick2: inputs loc_req, net_req, last_grant; outputs valid, grant. It is reused by later ports.

## Test plan

- Single local request with header 0x0123_4567_89AB_CDEF, tx_ack_i 3 cycles later:
  - tx_header_o equals the request header.
  - loc_ack_o pulses 1 cycle with ack_err_o = 0.
  - tx_cnt_o = 1.
- Both requests held continuously, ack given every time:
  - Grants after reset are net, loc, net, loc.
  - Acks alternate, and there is no back-to-back grant to the same source while the other is pending.
- TIMEOUT = 8 with no tx_ack_i:
  - tx_req_o is high exactly 8 cycles.
  - Ack carries ack_err_o = 1 and err_cnt_o = 1.
  - 300 further timeouts leave err_cnt_o = 255.
- link_ready_i = 0 during a local request: no tx_req_o is issued. link_ready_i deasserted mid-ST_TX gives an abort ack with err = 1.
- Both cases in ST_TX, each checked on the next edge:
  - tx_ack_i and the timeout in the same cycle give a success ack.
  - c_rst_ni pulsed low gives all outputs 0, no ack, and unchanged-to-zero counters.
